writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/regfile_bypass.sv | 52 +++++
 rtl/writeback_unit.sv | 84 ++++++++
 tb/tb_writeback_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction field layout, opcodes, datapath width
// and the writeback FSM state encoding.
package pipeline_pkg;

    localparam int DATA_W   = 20;
    localparam int INSTR_W  = 20;

    localparam int OPCODE_MSB = 19;
    localparam int OPCODE_LSB = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 13;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_LD   = 4'b0011;
    localparam logic [3:0] OP_ST   = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    function automatic logic is_write_op(input logic [3:0] opcode);
        return opcode inside {OP_ADD, OP_SUB, OP_LD, OP_ADDI};
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with a hard-wired zero register and two combinational read
// ports that forward the in-flight write data.
module regfile_bypass #(
    parameter int DATA_W   = 20,
    parameter int NUM_REGS = 8,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr_a,
    input  logic [ADDR_W-1:0] read_addr_b,
    output logic [DATA_W-1:0] read_data_a,
    output logic [DATA_W-1:0] read_data_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // NOTE: the array is built from flops, not a RAM macro, so it can and must be
    // cleared by reset; every register has to read 0 after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en && write_addr != '0) begin
            regs[write_addr] <= write_data;
        end
    end

    // NOTE: each output gets a default before the overrides so no latch is inferred.
    always_comb begin
        read_data_a = regs[read_addr_a];
        if (read_addr_a == '0) begin
            read_data_a = '0;
        end else if (write_en && read_addr_a == write_addr) begin
            read_data_a = write_data;
        end
    end

    always_comb begin
        read_data_b = regs[read_addr_b];
        if (read_addr_b == '0) begin
            read_data_b = '0;
        end else if (write_en && read_addr_b == write_addr) begin
            read_data_b = write_data;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: decodes the MEM/WB instruction, commits register writes,
// records the last write, counts retired instructions and handles HALT.
module writeback_unit #(
    parameter int DATA_W   = pipeline_pkg::DATA_W,
    parameter int NUM_REGS = 8,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [pipeline_pkg::INSTR_W-1:0]   instruction_wb,
    input  logic [DATA_W-1:0]                  alu_result_wb,
    input  logic [DATA_W-1:0]                  mem_data_wb,
    input  logic [ADDR_W-1:0]                  rd_addr_a,
    input  logic [ADDR_W-1:0]                  rd_addr_b,
    output logic [DATA_W-1:0]                  read_data_a,
    output logic [DATA_W-1:0]                  read_data_b,
    output logic                               wb_valid,
    output logic [ADDR_W-1:0]                  wb_reg,
    output logic [DATA_W-1:0]                  wb_data,
    output logic [15:0]                        retired_count,
    output logic                               halted
);

    import pipeline_pkg::*;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] rd;
    logic              write_en;
    logic [DATA_W-1:0] write_data;
    logic              unused_instr_bits;
    state_e            state;

    assign opcode            = instruction_wb[OPCODE_MSB:OPCODE_LSB];
    assign rd                = instruction_wb[RD_MSB:RD_LSB];
    assign unused_instr_bits = ^instruction_wb[RD_LSB-1:0];

    assign write_en   = (state == ST_RUN) && is_write_op(opcode) && (rd != '0);
    assign write_data = (opcode == OP_LD) ? mem_data_wb : alu_result_wb;

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clock       (clock),
        .reset       (reset),
        .write_en    (write_en),
        .write_addr  (rd),
        .write_data  (write_data),
        .read_addr_a (rd_addr_a),
        .read_addr_b (rd_addr_b),
        .read_data_a (read_data_a),
        .read_data_b (read_data_b)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_RUN;
            halted        <= 1'b0;
            retired_count <= '0;
            wb_valid      <= 1'b0;
            wb_reg        <= '0;
            wb_data       <= '0;
        end else begin
            wb_valid <= write_en;
            wb_reg   <= rd;
            wb_data  <= write_data;
            // HALT itself retires; after that the unit is frozen until reset.
            if (state == ST_RUN) begin
                if (opcode != OP_NOP && retired_count != COUNT_MAX) begin
                    retired_count <= retired_count + 16'd1;
                end
                if (opcode == OP_HALT) begin
                    state  <= ST_HALTED;
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized self-checking bench for writeback_unit against a behavioural
// register-file / counter / halt model.
module tb_writeback_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] instruction_wb = '0;
    logic [19:0] alu_result_wb  = '0;
    logic [19:0] mem_data_wb    = '0;
    logic [2:0]  rd_addr_a      = '0;
    logic [2:0]  rd_addr_b      = '0;
    logic [19:0] read_data_a;
    logic [19:0] read_data_b;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [19:0] wb_data;
    logic [15:0] retired_count;
    logic        halted;

    writeback_unit dut (
        .clock          (clock),
        .reset          (reset),
        .instruction_wb (instruction_wb),
        .alu_result_wb  (alu_result_wb),
        .mem_data_wb    (mem_data_wb),
        .rd_addr_a      (rd_addr_a),
        .rd_addr_b      (rd_addr_b),
        .read_data_a    (read_data_a),
        .read_data_b    (read_data_b),
        .wb_valid       (wb_valid),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .retired_count  (retired_count),
        .halted         (halted)
    );

    always #10 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [19:0] m_regs [8];
    int          m_count;
    bit          m_halted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] model_read(input logic [2:0] addr, input bit we,
                                               input logic [2:0] rd, input logic [19:0] wd);
        if (addr == 3'd0) return 20'd0;
        if (we && addr == rd) return wd;
        return m_regs[addr];
    endfunction

    // One instruction: drive, check reads before the edge, check records after it.
    task automatic step(input logic [3:0] op, input logic [2:0] rd, input logic [19:0] alu,
                        input logic [19:0] mem, input logic [2:0] ra, input logic [2:0] rb);
        bit          we;
        logic [19:0] wd;
        instruction_wb = {op, rd, 13'($urandom)};
        alu_result_wb  = alu;
        mem_data_wb    = mem;
        rd_addr_a      = ra;
        rd_addr_b      = rb;
        we = !m_halted && (op == 4'd1 || op == 4'd2 || op == 4'd3 || op == 4'd5) && rd != 3'd0;
        wd = (op == 4'd3) ? mem : alu;
        #1;
        check("read_a", read_data_a, model_read(ra, we, rd, wd));
        check("read_b", read_data_b, model_read(rb, we, rd, wd));
        @(posedge clock);
        #1;
        if (!m_halted) begin
            if (we) m_regs[rd] = wd;
            if (op != 4'd0 && m_count < 65535) m_count++;
            if (op == 4'hF) m_halted = 1'b1;
        end
        check("wb_valid", wb_valid, we);
        if (we) begin
            check("wb_reg", wb_reg, rd);
            check("wb_data", wb_data, wd);
        end
        check("retired_count", retired_count, m_count);
        check("halted", halted, m_halted);
    endtask

    // Walks every address on both ports with a NOP so no bypass is active.
    task automatic check_all_regs();
        instruction_wb = 20'd0;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            #1;
            check("regs_a", read_data_a, model_read(3'(i), 1'b0, 3'd0, 20'd0));
            check("regs_b", read_data_b, model_read(3'(7 - i), 1'b0, 3'd0, 20'd0));
        end
    endtask

    // Reset with a writing ADD present to show reset wins over the write.
    task automatic do_reset();
        reset          = 1'b1;
        instruction_wb = {4'h1, 3'd6, 13'd0};
        alu_result_wb  = 20'($urandom);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 20'd0;
        m_count  = 0;
        m_halted = 1'b0;
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_reg", wb_reg, 3'd0);
        check("rst_wb_data", wb_data, 20'd0);
        check("rst_count", retired_count, 16'd0);
        check("rst_halted", halted, 1'b0);
        check_all_regs();
    endtask

    initial begin
        logic [3:0] ops [3];
        ops[0] = 4'd1;
        ops[1] = 4'd2;
        ops[2] = 4'd5;

        do_reset();

        // Directed cases: ADD, LD, ADDI bypass, write to r0.
        step(4'd1, 3'd3, 20'h0ABCD, 20'($urandom), 3'd3, 3'd0);
        check("add_r3_wb_data", wb_data, 20'h0ABCD);
        rd_addr_a = 3'd3;
        instruction_wb = 20'd0;
        #1;
        check("add_r3_read", read_data_a, 20'h0ABCD);
        step(4'd3, 3'd5, 20'h00040, 20'h12345, 3'd1, 3'd5);
        rd_addr_b = 3'd5;
        instruction_wb = 20'd0;
        #1;
        check("ld_r5_read", read_data_b, 20'h12345);
        step(4'd5, 3'd2, 20'h00777, 20'($urandom), 3'd2, 3'd3);
        step(4'd1, 3'd0, 20'hFFFFF, 20'($urandom), 3'd0, 3'd0);
        check("r0_wb_valid", wb_valid, 1'b0);
        check_all_regs();

        // Random traffic in RUN (no HALT).
        for (int n = 0; n < 300; n++) begin
            step(4'($urandom_range(0, 14)), 3'($urandom), 20'($urandom), 20'($urandom),
                 3'($urandom), 3'($urandom));
        end
        check_all_regs();
        do_reset();

        // ADD, NOP, ST, HALT, ADD r1 -> three retired, r1 untouched.
        step(4'd1, 3'd4, 20'($urandom), 20'($urandom), 3'd4, 3'd1);
        step(4'd0, 3'd2, 20'($urandom), 20'($urandom), 3'd4, 3'd1);
        step(4'd4, 3'd3, 20'($urandom), 20'($urandom), 3'd4, 3'd1);
        step(4'hF, 3'd5, 20'($urandom), 20'($urandom), 3'd4, 3'd1);
        step(4'd1, 3'd1, 20'h00001, 20'($urandom), 3'd1, 3'd4);
        check("halt_seq_count", retired_count, 16'd3);
        check("halt_seq_halted", halted, 1'b1);
        rd_addr_a = 3'd1;
        instruction_wb = 20'd0;
        #1;
        check("halt_seq_r1", read_data_a, 20'd0);

        // Anything goes while halted: nothing may change, reads still work.
        for (int n = 0; n < 30; n++) begin
            step(4'($urandom), 3'($urandom), 20'($urandom), 20'($urandom),
                 3'($urandom), 3'($urandom));
        end
        check_all_regs();
        do_reset();

        // Saturation: walk the counter up to 0xFFFE, then three more.
        for (int n = 0; n < 65534; n++) begin
            step(4'd4, 3'($urandom), 20'($urandom), 20'($urandom), 3'($urandom), 3'($urandom));
        end
        check("sat_preload", retired_count, 16'hFFFE);
        for (int n = 0; n < 3; n++) begin
            step(ops[n], 3'($urandom), 20'($urandom), 20'($urandom), 3'($urandom), 3'($urandom));
        end
        check("sat_hold", retired_count, 16'hFFFF);
        check_all_regs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
